// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: next-PC select codes, R-format opcode, FSM states.
// The FAULT state is compiled in only when FETCH_ALIGN_CHECK_EN is defined.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    NextIns = 2'b00,
    Branch  = 2'b01,
    Jump    = 2'b10
  } pc_src_t;

  localparam logic [5:0]  opRFormat    = 6'b000000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    FAULT = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01
  } state_t;
`endif

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection: sequential, branch, J/JAL and JR targets.
// Without FETCH_ALIGN_CHECK_EN the low two bits are cleared so the PC is always word aligned.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [1:0]  pc_src,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc
);

  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] raw_pc;

  assign br_target  = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  // JR is the only jump carried by an R-format opcode; J/JAL splice the index into the current region
  assign jmp_target = (instr[31:26] == opRFormat) ? rs_data
                                                  : {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    raw_pc = pc_plus4;
    case (pc_src)
      Branch:  raw_pc = br_target;
      Jump:    raw_pc = jmp_target;
      default: raw_pc = pc_plus4;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign next_pc = raw_pc;
`else
  assign next_pc = {raw_pc[31:2], 2'b00};
`endif

endmodule

// File: rtl/fetch_unit.sv
// PC register and fetch FSM: one imem word per instruction, >=2 cycles each; ack latency stretches FETCH, hold stretches EXEC.
// FETCH_ALIGN_CHECK_EN adds a sticky addr_err and a FAULT state entered on a misaligned next PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        hold,
  input  logic [1:0]  PcSrc,
  input  logic [31:0] rs_data,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  output logic        ins_valid,
  output logic [31:0] instr,
  output logic [5:0]  Op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  Func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] next_pc;
  logic        retire;

  npc_calc u_npc_calc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .pc_src   (PcSrc),
    .rs_data  (rs_data),
    .next_pc  (next_pc)
  );

  assign retire = (state == EXEC) && !hold;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH: if (imem_ack) state_nx = EXEC;
      EXEC: begin
        if (!hold) begin
`ifdef FETCH_ALIGN_CHECK_EN
          state_nx = (next_pc[1:0] != 2'b00) ? FAULT : FETCH;
`else
          state_nx = FETCH;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: state_nx = FAULT;
`endif
      default: state_nx = FETCH;
    endcase
  end

  // Reset wins over a same-cycle ack, so a half-finished fetch is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if ((state == FETCH) && imem_ack) instr <= imem_rdata;
      if (retire)                       pc    <= next_pc;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                      addr_err <= 1'b0;
    else if (retire && (next_pc[1:0] != 2'b00))  addr_err <= 1'b1;
  end
`endif

  assign imem_req  = (state == FETCH);
  assign ins_valid = (state == EXEC);
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  assign Op   = instr[31:26];
  assign rs   = instr[25:21];
  assign rt   = instr[20:16];
  assign rd   = instr[15:11];
  assign Func = instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/jump targets, ack latency, hold, reset-abort, wrap, alignment.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        hold;
  logic [1:0]  PcSrc;
  logic [31:0] rs_data;
  logic        ins_valid;
  logic [31:0] instr;
  logic [5:0]  Op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  Func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .hold       (hold),
    .PcSrc      (PcSrc),
    .rs_data    (rs_data),
`ifdef FETCH_ALIGN_CHECK_EN
    .addr_err   (addr_err),
`endif
    .ins_valid  (ins_valid),
    .instr      (instr),
    .Op         (Op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .Func       (Func),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in FETCH; returns one cycle into the following FETCH (or FAULT).
  task automatic fetch_exec(input logic [31:0] word, input logic [1:0] src, input logic [31:0] rsv);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    PcSrc      = src;
    rs_data    = rsv;
    step();
    PcSrc      = 2'b00;
    rs_data    = 32'h0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    hold = 1'b0; PcSrc = 2'b00; rs_data = 32'h0;
    step();
    step();
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
`endif

    // first fetch, same-cycle ack
    rst = 1'b0;
    chk("f1_addr", imem_addr, 32'h0000_3000);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    chk("f1_ins_valid", {31'b0, ins_valid}, 32'd1);
    chk("f1_req_low", {31'b0, imem_req}, 32'd0);
    chk("f1_instr", instr, 32'h2008_0005);
    chk("f1_pc", pc, 32'h0000_3000);
    chk("f1_op", {26'b0, Op}, 32'h08);
    chk("f1_rt", {27'b0, rt}, 32'h08);
    chk("f1_pc_plus4", pc_plus4, 32'h0000_3004);
    step();
    chk("f1_next_addr", imem_addr, 32'h0000_3004);
    chk("f1_back_fetch", {31'b0, ins_valid}, 32'd0);

    // walk to 0x3010 and take a backward branch
    for (int i = 0; i < 3; i++) fetch_exec(32'h0000_0000, 2'b00, 32'h0);
    chk("pre_br_addr", imem_addr, 32'h0000_3010);
    fetch_exec(32'h1000_FFFE, 2'b01, 32'h0);
    chk("branch_addr", imem_addr, 32'h0000_300C);

    // PcSrc 2'b11 behaves as NextIns
    fetch_exec(32'h0000_0000, 2'b11, 32'hFFFF_FFF0);
    chk("src11_addr", imem_addr, 32'h0000_3010);
    for (int i = 0; i < 4; i++) fetch_exec(32'h0000_0000, 2'b00, 32'h0);
    chk("pre_j_addr", imem_addr, 32'h0000_3020);
    fetch_exec(32'h0800_0C10, 2'b10, 32'h0);
    chk("j_addr", imem_addr, 32'h0000_3040);
    fetch_exec(32'h03E0_0008, 2'b10, 32'h0000_3100);
    chk("jr_addr", imem_addr, 32'h0000_3100);

    // ack after 3 idle FETCH cycles, then 2 hold cycles
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dly_addr%0d", i), imem_addr, 32'h0000_3100);
      chk($sformatf("dly_req%0d", i), {31'b0, imem_req}, 32'd1);
      if (i == 3) begin imem_ack = 1'b1; imem_rdata = 32'h2009_0001; end
      step();
    end
    imem_ack = 1'b0;
    hold = 1'b1; PcSrc = 2'b01;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_valid%0d", i), {31'b0, ins_valid}, 32'd1);
      chk($sformatf("hold_pc%0d", i), pc, 32'h0000_3100);
      if (i == 2) begin hold = 1'b0; PcSrc = 2'b00; end
      step();
    end
    chk("hold_done_valid", {31'b0, ins_valid}, 32'd0);
    chk("hold_done_addr", imem_addr, 32'h0000_3104);

    // reset coinciding with ack discards the word
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("rstack_instr", instr, 32'h0);
    chk("rstack_addr", imem_addr, 32'h0000_3000);
    chk("rstack_req", {31'b0, imem_req}, 32'd1);
    chk("rstack_valid", {31'b0, ins_valid}, 32'd0);

    // top-of-memory wrap
    fetch_exec(32'h03E0_0008, 2'b10, 32'hFFFF_FFFC);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    fetch_exec(32'h0000_0000, 2'b00, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // misaligned JR target
    fetch_exec(32'h03E0_0008, 2'b10, 32'h0000_3102);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flt_err%0d", i), {31'b0, addr_err}, 32'd1);
      chk($sformatf("flt_req%0d", i), {31'b0, imem_req}, 32'd0);
      chk($sformatf("flt_valid%0d", i), {31'b0, ins_valid}, 32'd0);
      step();
    end
    chk("flt_pc", pc, 32'h0000_3102);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flt_clr_err", {31'b0, addr_err}, 32'd0);
    chk("flt_clr_req", {31'b0, imem_req}, 32'd1);
    chk("flt_clr_addr", imem_addr, 32'h0000_3000);
`else
    chk("misalign_addr", imem_addr, 32'h0000_3100);
    chk("misalign_req", {31'b0, imem_req}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
